// File: rtl/src_control_unit.sv
// Hardwired fetch/execute micro-sequencer for the Mini-SRC CPU.
// Optional macro CU_MULDIV_EN enables the mul/div sequences; without it they run as nop.
module src_control_unit (
  input  logic        clk,
  input  logic        in_reset,
  input  logic        in_stop,
  input  logic [31:0] in_ir,
  input  logic        in_branch,
  output logic        out_run,
  output logic        out_clear,
  output logic        out_gra,
  output logic        out_grb,
  output logic        out_grc,
  output logic        out_ba_read,
  output logic        out_regfile_read,
  output logic        out_hi_read,
  output logic        out_lo_read,
  output logic        out_z_hi_read,
  output logic        out_z_lo_read,
  output logic        out_pc_read,
  output logic        out_mdr_read,
  output logic        out_inport_read,
  output logic        out_c_read,
  output logic        out_regfile_write,
  output logic        out_hi_write,
  output logic        out_lo_write,
  output logic        out_z_write,
  output logic        out_pc_write,
  output logic        out_mdr_write,
  output logic        out_ir_write,
  output logic        out_y_write,
  output logic        out_mar_write,
  output logic        out_outport_write,
  output logic        out_conff_write,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic [3:0]  out_alu_opcode,
  output logic        out_mdr_select,
  output logic        out_inc_pc
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_T8, S_T9, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE, C_IMM, C_LDI, C_LD, C_ST, C_MULDIV, C_NEGNOT, C_BR,
    C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT, C_NOP
  } op_class_t;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SHR = 4'd2;
  localparam logic [3:0] ALU_SHL = 4'd3;
  localparam logic [3:0] ALU_ROR = 4'd4;
  localparam logic [3:0] ALU_ROL = 4'd5;
  localparam logic [3:0] ALU_AND = 4'd6;
  localparam logic [3:0] ALU_OR  = 4'd7;
`ifdef CU_MULDIV_EN
  localparam logic [3:0] ALU_MUL = 4'd8;
  localparam logic [3:0] ALU_DIV = 4'd9;
`endif
  localparam logic [3:0] ALU_NEG = 4'd10;
  localparam logic [3:0] ALU_NOT = 4'd11;

  state_t     state;
  state_t     next_state;
  op_class_t  op_class;
  logic [3:0] op_alu;
  logic [4:0] opcode;
  logic       done;
  logic       unused_ir;

  assign opcode    = in_ir[31:27];
  assign unused_ir = ^in_ir[26:0];

  function automatic state_t step_after(input state_t s);
    case (s)
      S_T4:    step_after = S_T5;
      S_T5:    step_after = S_T6;
      S_T6:    step_after = S_T7;
      S_T7:    step_after = S_T8;
      S_T8:    step_after = S_T9;
      default: step_after = S_T0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (in_reset)
      state <= S_RESET;
    else
      state <= next_state;
  end

  // Opcode -> execute sequence family plus the ALU function it issues.
  always_comb begin
    op_class = C_NOP;
    op_alu   = ALU_ADD;
    case (opcode)
      5'b00000: op_class = C_LD;
      5'b00001: op_class = C_LDI;
      5'b00010: op_class = C_ST;
      5'b00011: begin op_class = C_RTYPE; op_alu = ALU_ADD; end
      5'b00100: begin op_class = C_RTYPE; op_alu = ALU_SUB; end
      5'b00101: begin op_class = C_RTYPE; op_alu = ALU_SHR; end
      5'b00110: begin op_class = C_RTYPE; op_alu = ALU_SHL; end
      5'b00111: begin op_class = C_RTYPE; op_alu = ALU_ROR; end
      5'b01000: begin op_class = C_RTYPE; op_alu = ALU_ROL; end
      5'b01001: begin op_class = C_RTYPE; op_alu = ALU_AND; end
      5'b01010: begin op_class = C_RTYPE; op_alu = ALU_OR;  end
      5'b01011: begin op_class = C_IMM;   op_alu = ALU_ADD; end
      5'b01100: begin op_class = C_IMM;   op_alu = ALU_AND; end
      5'b01101: begin op_class = C_IMM;   op_alu = ALU_OR;  end
`ifdef CU_MULDIV_EN
      5'b01110: begin op_class = C_MULDIV; op_alu = ALU_MUL; end
      5'b01111: begin op_class = C_MULDIV; op_alu = ALU_DIV; end
`endif
      5'b10000: begin op_class = C_NEGNOT; op_alu = ALU_NEG; end
      5'b10001: begin op_class = C_NEGNOT; op_alu = ALU_NOT; end
      5'b10010: op_class = C_BR;
      5'b10011: op_class = C_JR;
      5'b10100: op_class = C_JAL;
      5'b10101: op_class = C_IN;
      5'b10110: op_class = C_OUT;
      5'b10111: op_class = C_MFHI;
      5'b11000: op_class = C_MFLO;
      5'b11010: op_class = C_HALT;
      default:  op_class = C_NOP;
    endcase
  end

  always_comb begin
    out_run           = 1'b1;
    out_clear         = 1'b0;
    out_gra           = 1'b0;
    out_grb           = 1'b0;
    out_grc           = 1'b0;
    out_ba_read       = 1'b0;
    out_regfile_read  = 1'b0;
    out_hi_read       = 1'b0;
    out_lo_read       = 1'b0;
    out_z_hi_read     = 1'b0;
    out_z_lo_read     = 1'b0;
    out_pc_read       = 1'b0;
    out_mdr_read      = 1'b0;
    out_inport_read   = 1'b0;
    out_c_read        = 1'b0;
    out_regfile_write = 1'b0;
    out_hi_write      = 1'b0;
    out_lo_write      = 1'b0;
    out_z_write       = 1'b0;
    out_pc_write      = 1'b0;
    out_mdr_write     = 1'b0;
    out_ir_write      = 1'b0;
    out_y_write       = 1'b0;
    out_mar_write     = 1'b0;
    out_outport_write = 1'b0;
    out_conff_write   = 1'b0;
    out_mem_read      = 1'b0;
    out_mem_write     = 1'b0;
    out_alu_opcode    = ALU_ADD;
    out_mdr_select    = 1'b0;
    out_inc_pc        = 1'b0;
    next_state        = state;
    done              = 1'b0;

    case (state)
      S_RESET: begin
        out_clear  = 1'b1;
        next_state = S_T0;
      end
      // A stop request is only honoured at an instruction boundary.
      S_T0: begin
        if (in_stop) begin
          out_run    = 1'b0;
          next_state = S_HALT;
        end else begin
          out_pc_read   = 1'b1;
          out_mar_write = 1'b1;
          out_inc_pc    = 1'b1;
          next_state    = S_T1;
        end
      end
      S_T1: begin
        out_mem_read = 1'b1;
        next_state   = S_T2;
      end
      S_T2: begin
        out_mem_read   = 1'b1;
        out_mdr_select = 1'b1;
        out_mdr_write  = 1'b1;
        next_state     = S_T3;
      end
      S_T3: begin
        out_mdr_read = 1'b1;
        out_ir_write = 1'b1;
        next_state   = S_T4;
      end
      S_HALT: begin
        out_run    = 1'b0;
        next_state = S_HALT;
      end
      default: begin
        case (op_class)
          C_RTYPE, C_IMM: begin
            case (state)
              S_T4: begin
                out_grb = 1'b1; out_regfile_read = 1'b1; out_y_write = 1'b1;
              end
              S_T5: begin
                if (op_class == C_IMM) begin
                  out_c_read = 1'b1;
                end else begin
                  out_grc = 1'b1; out_regfile_read = 1'b1;
                end
                out_alu_opcode = op_alu; out_z_write = 1'b1;
              end
              S_T6: begin
                out_z_lo_read = 1'b1; out_gra = 1'b1; out_regfile_write = 1'b1; done = 1'b1;
              end
              default: done = 1'b1;
            endcase
          end
          // ldi/ld/st share the effective-address computation Rb(or 0)+C.
          C_LDI, C_LD, C_ST: begin
            case (state)
              S_T4: begin
                out_grb = 1'b1; out_ba_read = 1'b1; out_y_write = 1'b1;
              end
              S_T5: begin
                out_c_read = 1'b1; out_alu_opcode = ALU_ADD; out_z_write = 1'b1;
              end
              S_T6: begin
                out_z_lo_read = 1'b1;
                if (op_class == C_LDI) begin
                  out_gra = 1'b1; out_regfile_write = 1'b1; done = 1'b1;
                end else begin
                  out_mar_write = 1'b1;
                end
              end
              S_T7: begin
                if (op_class == C_LD) begin
                  out_mem_read = 1'b1;
                end else begin
                  out_gra = 1'b1; out_regfile_read = 1'b1; out_mdr_write = 1'b1;
                end
              end
              S_T8: begin
                if (op_class == C_LD) begin
                  out_mem_read = 1'b1; out_mdr_select = 1'b1; out_mdr_write = 1'b1;
                end else begin
                  out_mem_write = 1'b1; done = 1'b1;
                end
              end
              S_T9: begin
                out_mdr_read = 1'b1; out_gra = 1'b1; out_regfile_write = 1'b1; done = 1'b1;
              end
              default: done = 1'b1;
            endcase
          end
`ifdef CU_MULDIV_EN
          C_MULDIV: begin
            case (state)
              S_T4: begin
                out_gra = 1'b1; out_regfile_read = 1'b1; out_y_write = 1'b1;
              end
              S_T5: begin
                out_grb = 1'b1; out_regfile_read = 1'b1;
                out_alu_opcode = op_alu; out_z_write = 1'b1;
              end
              S_T6: begin
                out_z_lo_read = 1'b1; out_lo_write = 1'b1;
              end
              S_T7: begin
                out_z_hi_read = 1'b1; out_hi_write = 1'b1; done = 1'b1;
              end
              default: done = 1'b1;
            endcase
          end
`endif
          C_NEGNOT: begin
            if (state == S_T4) begin
              out_grb = 1'b1; out_regfile_read = 1'b1;
              out_alu_opcode = op_alu; out_z_write = 1'b1;
            end else begin
              out_z_lo_read = 1'b1; out_gra = 1'b1; out_regfile_write = 1'b1; done = 1'b1;
            end
          end
          // Target is PC+C; CON FF decides at T7 whether PC is reloaded.
          C_BR: begin
            case (state)
              S_T4: begin
                out_gra = 1'b1; out_regfile_read = 1'b1; out_conff_write = 1'b1;
              end
              S_T5: begin
                out_pc_read = 1'b1; out_y_write = 1'b1;
              end
              S_T6: begin
                out_c_read = 1'b1; out_alu_opcode = ALU_ADD; out_z_write = 1'b1;
              end
              default: begin
                if (in_branch) begin
                  out_z_lo_read = 1'b1; out_pc_write = 1'b1;
                end
                done = 1'b1;
              end
            endcase
          end
          C_JR: begin
            out_gra = 1'b1; out_regfile_read = 1'b1; out_pc_write = 1'b1; done = 1'b1;
          end
          C_JAL: begin
            if (state == S_T4) begin
              out_pc_read = 1'b1; out_grb = 1'b1; out_regfile_write = 1'b1;
            end else begin
              out_gra = 1'b1; out_regfile_read = 1'b1; out_pc_write = 1'b1; done = 1'b1;
            end
          end
          C_IN: begin
            out_inport_read = 1'b1; out_gra = 1'b1; out_regfile_write = 1'b1; done = 1'b1;
          end
          C_OUT: begin
            out_gra = 1'b1; out_regfile_read = 1'b1; out_outport_write = 1'b1; done = 1'b1;
          end
          C_MFHI: begin
            out_hi_read = 1'b1; out_gra = 1'b1; out_regfile_write = 1'b1; done = 1'b1;
          end
          C_MFLO: begin
            out_lo_read = 1'b1; out_gra = 1'b1; out_regfile_write = 1'b1; done = 1'b1;
          end
          default: done = 1'b1;
        endcase

        if (op_class == C_HALT)
          next_state = S_HALT;
        else
          next_state = done ? S_T0 : step_after(state);
      end
    endcase
  end

endmodule

// File: tb/tb_src_control_unit.sv
// Scoreboard bench for src_control_unit: stimulus queues expected output vectors per cycle,
// a monitor pops and compares them at each falling edge.
module tb_src_control_unit;

  logic        clk;
  logic        in_reset;
  logic        in_stop;
  logic [31:0] in_ir;
  logic        in_branch;
  logic        out_run, out_clear, out_gra, out_grb, out_grc, out_ba_read, out_regfile_read;
  logic        out_hi_read, out_lo_read, out_z_hi_read, out_z_lo_read, out_pc_read;
  logic        out_mdr_read, out_inport_read, out_c_read;
  logic        out_regfile_write, out_hi_write, out_lo_write, out_z_write, out_pc_write;
  logic        out_mdr_write, out_ir_write, out_y_write, out_mar_write, out_outport_write;
  logic        out_conff_write, out_mem_read, out_mem_write, out_mdr_select, out_inc_pc;
  logic [3:0]  out_alu_opcode;
  logic [33:0] actual;

  localparam logic [33:0] RUN     = 34'd1 << 33;
  localparam logic [33:0] CLEAR   = 34'd1 << 32;
  localparam logic [33:0] GRA     = 34'd1 << 31;
  localparam logic [33:0] GRB     = 34'd1 << 30;
  localparam logic [33:0] GRC     = 34'd1 << 29;
  localparam logic [33:0] BA_R    = 34'd1 << 28;
  localparam logic [33:0] RF_R    = 34'd1 << 27;
  localparam logic [33:0] HI_R    = 34'd1 << 26;
  localparam logic [33:0] LO_R    = 34'd1 << 25;
  localparam logic [33:0] ZHI_R   = 34'd1 << 24;
  localparam logic [33:0] ZLO_R   = 34'd1 << 23;
  localparam logic [33:0] PC_R    = 34'd1 << 22;
  localparam logic [33:0] MDR_R   = 34'd1 << 21;
  localparam logic [33:0] IN_R    = 34'd1 << 20;
  localparam logic [33:0] C_R     = 34'd1 << 19;
  localparam logic [33:0] RF_W    = 34'd1 << 18;
  localparam logic [33:0] HI_W    = 34'd1 << 17;
  localparam logic [33:0] LO_W    = 34'd1 << 16;
  localparam logic [33:0] Z_W     = 34'd1 << 15;
  localparam logic [33:0] PC_W    = 34'd1 << 14;
  localparam logic [33:0] MDR_W   = 34'd1 << 13;
  localparam logic [33:0] IR_W    = 34'd1 << 12;
  localparam logic [33:0] Y_W     = 34'd1 << 11;
  localparam logic [33:0] MAR_W   = 34'd1 << 10;
  localparam logic [33:0] OUT_W   = 34'd1 << 9;
  localparam logic [33:0] CON_W   = 34'd1 << 8;
  localparam logic [33:0] MEM_R   = 34'd1 << 7;
  localparam logic [33:0] MEM_W   = 34'd1 << 6;
  localparam logic [33:0] MDR_SEL = 34'd1 << 5;
  localparam logic [33:0] INC_PC  = 34'd1 << 4;

  string       name_q[$];
  logic [33:0] exp_q[$];
  int          tests_run;
  int          fail_count;
  logic [31:0] cur_ir;

  src_control_unit dut (
    .clk(clk), .in_reset(in_reset), .in_stop(in_stop), .in_ir(in_ir), .in_branch(in_branch),
    .out_run(out_run), .out_clear(out_clear), .out_gra(out_gra), .out_grb(out_grb),
    .out_grc(out_grc), .out_ba_read(out_ba_read), .out_regfile_read(out_regfile_read),
    .out_hi_read(out_hi_read), .out_lo_read(out_lo_read), .out_z_hi_read(out_z_hi_read),
    .out_z_lo_read(out_z_lo_read), .out_pc_read(out_pc_read), .out_mdr_read(out_mdr_read),
    .out_inport_read(out_inport_read), .out_c_read(out_c_read),
    .out_regfile_write(out_regfile_write), .out_hi_write(out_hi_write),
    .out_lo_write(out_lo_write), .out_z_write(out_z_write), .out_pc_write(out_pc_write),
    .out_mdr_write(out_mdr_write), .out_ir_write(out_ir_write), .out_y_write(out_y_write),
    .out_mar_write(out_mar_write), .out_outport_write(out_outport_write),
    .out_conff_write(out_conff_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_alu_opcode(out_alu_opcode),
    .out_mdr_select(out_mdr_select), .out_inc_pc(out_inc_pc)
  );

  assign actual = {out_run, out_clear, out_gra, out_grb, out_grc, out_ba_read, out_regfile_read,
                   out_hi_read, out_lo_read, out_z_hi_read, out_z_lo_read, out_pc_read,
                   out_mdr_read, out_inport_read, out_c_read, out_regfile_write, out_hi_write,
                   out_lo_write, out_z_write, out_pc_write, out_mdr_write, out_ir_write,
                   out_y_write, out_mar_write, out_outport_write, out_conff_write,
                   out_mem_read, out_mem_write, out_mdr_select, out_inc_pc, out_alu_opcode};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string nm, input logic [33:0] exp);
    tests_run++;
    if (actual !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", nm, actual, exp);
    end
  endtask

  // Monitor: every falling edge with a pending expectation is compared.
  initial begin
    string       nm;
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        nm = name_q.pop_front();
        e  = exp_q.pop_front();
        checkOutput(nm, e);
      end
    end
  end

  // Called just after a rising edge: drives inputs for the current cycle and queues
  // the outputs expected during it; the reset value takes effect at the next edge.
  task automatic applyStimulus(input string nm, input logic rst, input logic stop,
                               input logic br, input logic [33:0] exp);
    in_reset  = rst;
    in_stop   = stop;
    in_branch = br;
    in_ir     = cur_ir;
    name_q.push_back(nm);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic doFetch(input string lbl, input logic [31:0] ir);
    cur_ir = ir;
    applyStimulus({lbl, " T0"}, 1'b0, 1'b0, 1'b0, RUN | PC_R | MAR_W | INC_PC);
    applyStimulus({lbl, " T1"}, 1'b0, 1'b0, 1'b0, RUN | MEM_R);
    applyStimulus({lbl, " T2"}, 1'b0, 1'b0, 1'b0, RUN | MEM_R | MDR_SEL | MDR_W);
    applyStimulus({lbl, " T3"}, 1'b0, 1'b0, 1'b0, RUN | MDR_R | IR_W);
  endtask

  initial begin
    tests_run  = 0;
    fail_count = 0;
    cur_ir     = 32'h0;
    in_reset   = 1'b1;
    in_stop    = 1'b0;
    in_branch  = 1'b0;
    in_ir      = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;

    applyStimulus("reset", 1'b0, 1'b0, 1'b0, RUN | CLEAR);

    doFetch("add", 32'h18918000);
    applyStimulus("add T4", 1'b0, 1'b0, 1'b0, RUN | GRB | RF_R | Y_W);
    applyStimulus("add T5", 1'b0, 1'b0, 1'b0, RUN | GRC | RF_R | Z_W | 34'd0);
    applyStimulus("add T6", 1'b0, 1'b0, 1'b0, RUN | ZLO_R | GRA | RF_W);

    doFetch("ld", 32'h00800000);
    applyStimulus("ld T4", 1'b0, 1'b0, 1'b0, RUN | GRB | BA_R | Y_W);
    applyStimulus("ld T5", 1'b0, 1'b0, 1'b0, RUN | C_R | Z_W);
    applyStimulus("ld T6", 1'b0, 1'b0, 1'b0, RUN | ZLO_R | MAR_W);
    applyStimulus("ld T7", 1'b0, 1'b0, 1'b0, RUN | MEM_R);
    applyStimulus("ld T8", 1'b0, 1'b0, 1'b0, RUN | MEM_R | MDR_SEL | MDR_W);
    applyStimulus("ld T9", 1'b0, 1'b0, 1'b0, RUN | MDR_R | GRA | RF_W);

    doFetch("st", 32'h10000000);
    applyStimulus("st T4", 1'b0, 1'b0, 1'b0, RUN | GRB | BA_R | Y_W);
    applyStimulus("st T5", 1'b0, 1'b0, 1'b0, RUN | C_R | Z_W);
    applyStimulus("st T6", 1'b0, 1'b0, 1'b0, RUN | ZLO_R | MAR_W);
    applyStimulus("st T7", 1'b0, 1'b0, 1'b0, RUN | GRA | RF_R | MDR_W);
    applyStimulus("st T8", 1'b0, 1'b0, 1'b0, RUN | MEM_W);

    doFetch("shr", 32'h28000000);
    applyStimulus("shr T4", 1'b0, 1'b0, 1'b0, RUN | GRB | RF_R | Y_W);
    applyStimulus("shr T5", 1'b0, 1'b0, 1'b0, RUN | GRC | RF_R | Z_W | 34'd2);
    applyStimulus("shr T6", 1'b0, 1'b0, 1'b0, RUN | ZLO_R | GRA | RF_W);

    doFetch("andi", 32'h60000000);
    applyStimulus("andi T4", 1'b0, 1'b0, 1'b0, RUN | GRB | RF_R | Y_W);
    applyStimulus("andi T5", 1'b0, 1'b0, 1'b0, RUN | C_R | Z_W | 34'd6);
    applyStimulus("andi T6", 1'b0, 1'b0, 1'b0, RUN | ZLO_R | GRA | RF_W);

    doFetch("br1", 32'h90000000);
    applyStimulus("br1 T4", 1'b0, 1'b0, 1'b0, RUN | GRA | RF_R | CON_W);
    applyStimulus("br1 T5", 1'b0, 1'b0, 1'b0, RUN | PC_R | Y_W);
    applyStimulus("br1 T6", 1'b0, 1'b0, 1'b0, RUN | C_R | Z_W);
    applyStimulus("br1 T7 taken", 1'b0, 1'b0, 1'b1, RUN | ZLO_R | PC_W);

    doFetch("br0", 32'h90000000);
    applyStimulus("br0 T4", 1'b0, 1'b0, 1'b0, RUN | GRA | RF_R | CON_W);
    applyStimulus("br0 T5", 1'b0, 1'b0, 1'b0, RUN | PC_R | Y_W);
    applyStimulus("br0 T6", 1'b0, 1'b0, 1'b0, RUN | C_R | Z_W);
    applyStimulus("br0 T7 not taken", 1'b0, 1'b0, 1'b0, RUN);

    doFetch("neg", 32'h80000000);
    applyStimulus("neg T4", 1'b0, 1'b0, 1'b0, RUN | GRB | RF_R | Z_W | 34'd10);
    applyStimulus("neg T5", 1'b0, 1'b0, 1'b0, RUN | ZLO_R | GRA | RF_W);

    doFetch("jal", 32'hA0000000);
    applyStimulus("jal T4", 1'b0, 1'b0, 1'b0, RUN | PC_R | GRB | RF_W);
    applyStimulus("jal T5", 1'b0, 1'b0, 1'b0, RUN | GRA | RF_R | PC_W);

    doFetch("mfhi", 32'hB8000000);
    applyStimulus("mfhi T4", 1'b0, 1'b0, 1'b0, RUN | HI_R | GRA | RF_W);

    doFetch("mul", 32'h70000000);
`ifdef CU_MULDIV_EN
    applyStimulus("mul T4", 1'b0, 1'b0, 1'b0, RUN | GRA | RF_R | Y_W);
    applyStimulus("mul T5", 1'b0, 1'b0, 1'b0, RUN | GRB | RF_R | Z_W | 34'd8);
    applyStimulus("mul T6", 1'b0, 1'b0, 1'b0, RUN | ZLO_R | LO_W);
    applyStimulus("mul T7", 1'b0, 1'b0, 1'b0, RUN | ZHI_R | HI_W);
`else
    applyStimulus("mul as nop T4", 1'b0, 1'b0, 1'b0, RUN);
`endif

    doFetch("nop", 32'hC8000000);
    applyStimulus("nop T4", 1'b0, 1'b0, 1'b0, RUN);

    // Stop raised mid-instruction: the add finishes, then the next T0 halts.
    doFetch("stop", 32'h18918000);
    applyStimulus("stop T4", 1'b0, 1'b0, 1'b0, RUN | GRB | RF_R | Y_W);
    applyStimulus("stop T5 ignored", 1'b0, 1'b1, 1'b0, RUN | GRC | RF_R | Z_W);
    applyStimulus("stop T6 ignored", 1'b0, 1'b1, 1'b0, RUN | ZLO_R | GRA | RF_W);
    applyStimulus("stop at T0", 1'b0, 1'b1, 1'b0, 34'd0);
    applyStimulus("stop halted", 1'b0, 1'b0, 1'b0, 34'd0);
    applyStimulus("stop halted rst", 1'b1, 1'b0, 1'b0, 34'd0);
    applyStimulus("stop reset", 1'b0, 1'b0, 1'b0, RUN | CLEAR);

    doFetch("halt", 32'hD0000000);
    applyStimulus("halt T4", 1'b0, 1'b0, 1'b0, RUN);
    applyStimulus("halted 1", 1'b0, 1'b0, 1'b0, 34'd0);
    applyStimulus("halted 2", 1'b0, 1'b1, 1'b0, 34'd0);
    applyStimulus("halted 3 rst", 1'b1, 1'b0, 1'b0, 34'd0);
    applyStimulus("halt reset", 1'b0, 1'b0, 1'b0, RUN | CLEAR);
    cur_ir = 32'h0;
    applyStimulus("restart T0", 1'b0, 1'b0, 1'b0, RUN | PC_R | MAR_W | INC_PC);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      fail_count++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule

// File: doc/src_control_unit.md
Name: src_control_unit

Overview:
- Hardwired micro-sequencer for the Mini-SRC 32-bit CPU.
- Each instruction runs as fetch (T0–T3) and then execute steps (T4 onward), driving one-hot read/write strobes to datapath, memory, select/encode logic and the CON FF.
- Sits between the IR/CON-FF outputs and every datapath control input.

Parameters:
- none

Ports:
- clk  in  1  system clock, rising edge
- in_reset  in  1  synchronous, active-high reset
- in_stop  in  1  external stop request
- in_ir  in  32  instruction register; opcode = in_ir[31:27]
- in_branch  in  1  CON FF result (1 = take branch)
- out_run  out  1  1 while executing, 0 when halted
- out_clear  out  1  datapath register clear
- out_gra, out_grb, out_grc  out  1 each  select IR Ra / Rb / Rc field
- out_ba_read  out  1  base-address read (R0 reads as 0)
- out_regfile_read  out  1  register-file read strobe
- out_hi_read, out_lo_read, out_z_hi_read, out_z_lo_read, out_pc_read, out_mdr_read, out_inport_read, out_c_read  out  1 each  bus drivers
- out_regfile_write, out_hi_write, out_lo_write, out_z_write, out_pc_write, out_mdr_write, out_ir_write, out_y_write, out_mar_write, out_outport_write, out_conff_write  out  1 each  register load enables
- out_mem_read, out_mem_write  out  1 each  synchronous RAM strobes
- out_alu_opcode  out  4  0 ADD, 1 SUB, 2 SHR, 3 SHL, 4 ROR, 5 ROL, 6 AND, 7 OR, 8 MUL, 9 DIV, 10 NEG, 11 NOT
- out_mdr_select  out  1  1 = MDR loads memory q, 0 = MDR loads bus
- out_inc_pc  out  1  PC self-increment

Behaviour:
- The step state is registered on the clk rising edge. All outputs are combinational decode of state plus IR.
- Every output not listed for a step is 0. out_alu_opcode defaults to 0.
- Reset:
  - in_reset=1 at an edge puts the unit in RESET. RESET has precedence over all else.
  - In RESET: out_clear=1, out_run=1, all other outputs 0. The next state is T0.
- Stop and halt:
  - In T0, if in_stop=1, go to HALT and assert none of the T0 signals.
  - Opcode 11010 (halt) at T4 also goes to HALT.
  - HALT: out_run=0, all strobes 0. HALT is left only by reset.
  - in_stop is ignored outside T0.
- Fetch:
  - T0: pc_read, mar_write, inc_pc.
  - T1: mem_read.
  - T2: mem_read, mdr_select=1, mdr_write.
  - T3: mdr_read, ir_write.
- Execute, from T4, by opcode. The last listed step returns to T0.
  - R-type (add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010):
    - T4: grb, regfile_read, y_write.
    - T5: grc, regfile_read, op, z_write.
    - T6: z_lo_read, gra, regfile_write.
  - Immediate (addi 01011 = ADD, andi 01100 = AND, ori 01101 = OR): same as R-type, except T5 uses c_read in place of grc/regfile_read.
  - ldi 00001:
    - T4: grb, ba_read, y_write.
    - T5: c_read, ADD, z_write.
    - T6: z_lo_read, gra, regfile_write.
  - ld 00000:
    - T4, T5 as ldi.
    - T6: z_lo_read, mar_write.
    - T7: mem_read.
    - T8: mem_read, mdr_select=1, mdr_write.
    - T9: mdr_read, gra, regfile_write.
  - st 00010:
    - T4–T6 as ld.
    - T7: gra, regfile_read, mdr_select=0, mdr_write.
    - T8: mem_write.
  - mul 01110 / div 01111:
    - T4: gra, regfile_read, y_write.
    - T5: grb, regfile_read, op, z_write.
    - T6: z_lo_read, lo_write.
    - T7: z_hi_read, hi_write.
  - neg 10000 / not 10001:
    - T4: grb, regfile_read, op, z_write.
    - T5: z_lo_read, gra, regfile_write.
  - branch 10010:
    - T4: gra, regfile_read, conff_write.
    - T5: pc_read, y_write.
    - T6: c_read, ADD, z_write.
    - T7: if in_branch=1, z_lo_read and pc_write; otherwise no strobes.
  - jr 10011:
    - T4: gra, regfile_read, pc_write.
  - jal 10100 (link register is encoded in the Rb field):
    - T4: pc_read, grb, regfile_write.
    - T5: gra, regfile_read, pc_write.
  - in 10101 — T4: inport_read, gra, regfile_write.
  - out 10110 — T4: gra, regfile_read, outport_write.
  - mfhi 10111 — T4: hi_read, gra, regfile_write.
  - mflo 11000 — T4: lo_read, gra, regfile_write.
  - nop 11001, and any opcode 11011–11111: T4 with no strobes, then T0.
- Exclusivity: at most one bus-driver output is high in any step.

Optional Feature:
- Macro CU_MULDIV_EN.
- Defined: mul/div sequences as specified above.
- Undefined: opcodes 01110 and 01111 execute as nop (single empty T4). ALU codes 8/9 are never issued.

Test Plan:
- Reset held 1 cycle, then released: out_clear=1 and out_run=1 during reset. Next cycle (T0): pc_read=mar_write=inc_pc=1, clear=0.
- Fetch with in_ir=add R1,R2,R3 (0x18918000): T3 ir_write=1. T4 grb+regfile_read+y_write. T5 grc+alu_opcode=0+z_write. T6 z_lo_read+gra+regfile_write. Then back to T0.
- ld (opcode 00000): mar_write at T6, mem_read at T7/T8 with mdr_select=1 and mdr_write at T8, regfile_write at T9. Total 10 cycles per instruction.
- Branch opcode 10010:
  - in_branch=1 → pc_write=1 with z_lo_read at T7.
  - in_branch=0 → all strobes 0 at T7.
- Halt opcode 11010 → out_run=0 from the cycle after T4 and stays 0. A 1-cycle in_reset returns out_run to 1 and restarts at T0.
- in_stop=1 asserted mid-instruction:
  - Instruction completes.
  - At the following T0, out_run=0 and pc_read=0.
